tia_hmove_sequencer: RTL

Sequences horizontal-motion (HMOVE) extra clocking for the TIA motion-object position counters (P0, P1, M0, M1, BL).
- Holds one 4-bit motion register per object.
- On an HMOVE strobe, emits a burst of extra single-cycle clock pulses per object. These are OR-ed into each counter's motck path, shifting its start_bar position.
- Sits between the register-write decoder and the per-object position counters.

---
 rtl/tia_hmove_pkg.sv | 22 ++
 rtl/tia_hmove_compare.sv | 32 +++
 rtl/tia_hmove_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/tia_hmove_pkg.sv
// Shared constants and state type for the TIA HMOVE sequencer.
package tia_hmove_pkg;

    // Motion-object indices
    localparam int OBJ_P0 = 0;
    localparam int OBJ_P1 = 1;
    localparam int OBJ_M0 = 2;
    localparam int OBJ_M1 = 3;
    localparam int OBJ_BL = 4;
    localparam int N_OBJ  = 5;

    // Motion register width and number of paced steps in one sequence
    localparam int HM_W       = 4;
    localparam int STEP_LIMIT = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } hm_state_e;

endpackage

// File: rtl/tia_hmove_compare.sv
// Per-object motion register and live "step < pulse count" comparator.
// Pulse count is the signed motion value with its sign bit flipped
// (reg XOR 8 for a 4-bit register), giving 0..15 pulses.
module tia_hmove_compare #(
    parameter int HM_W = tia_hmove_pkg::HM_W
) (
    input  logic            clk,
    input  logic            reset_bar,
    input  logic            wr,
    input  logic            clr,
    input  logic [HM_W-1:0] data,
    input  logic [HM_W-1:0] step,
    output logic            hit
);

    logic [HM_W-1:0] motion;
    logic [HM_W-1:0] pulses;

    // Motion register: clear takes priority over a same-cycle write
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar)
            motion <= '0;
        else if (clr)
            motion <= '0;
        else if (wr)
            motion <= data;
    end

    assign pulses = {~motion[HM_W-1], motion[HM_W-2:0]};
    assign hit    = (step < pulses);

endmodule

// File: rtl/tia_hmove_sequencer.sv
// HMOVE extra-clock sequencer for the five TIA motion objects.
// Optional: define TIA_HMOVE_LATE_HBLANK_EN to add the hblank input and
// the late_hblank output (8-clk HBLANK extension after an HMOVE line).
module tia_hmove_sequencer #(
    parameter int NUM_OBJ = tia_hmove_pkg::N_OBJ,
    parameter int HM_W    = tia_hmove_pkg::HM_W
) (
    input  logic               clk,
    input  logic               reset_bar,
    input  logic               hm_tick,
    input  logic               hmove,
    input  logic               hmclr,
    input  logic [NUM_OBJ-1:0] hm_wr,
    input  logic [HM_W-1:0]    hm_data,
    output logic [NUM_OBJ-1:0] extra_clk,
    output logic               busy
`ifdef TIA_HMOVE_LATE_HBLANK_EN
    ,
    input  logic               hblank,
    output logic               late_hblank
`endif
);

    import tia_hmove_pkg::*;

    localparam logic [HM_W-1:0] LAST_STEP = HM_W'(STEP_LIMIT - 1);

    hm_state_e          state;
    logic [HM_W-1:0]    step;
    logic [NUM_OBJ-1:0] hit;

    // One register + comparator per object; compare is live against the
    // current register contents, so mid-run writes shape later steps.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_OBJ; gi++) begin : g_obj
            tia_hmove_compare #(.HM_W(HM_W)) u_cmp (
                .clk       (clk),
                .reset_bar (reset_bar),
                .wr        (hm_wr[gi]),
                .clr       (hmclr),
                .data      (hm_data),
                .step      (step),
                .hit       (hit[gi])
            );
        end
    endgenerate

    // Sequencer FSM: hmove (re)arms with step 0; each hm_tick in ARMED/RUN
    // issues one step of pulses, ending after the last step.
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            state     <= ST_IDLE;
            step      <= '0;
            busy      <= 1'b0;
            extra_clk <= '0;
        end else begin
            extra_clk <= '0;
            case (state)
                ST_IDLE: begin
                    if (hmove) begin
                        state <= ST_ARMED;
                        step  <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_ARMED, ST_RUN: begin
                    if (hmove) begin
                        state <= ST_ARMED;
                        step  <= '0;
                    end else if (hm_tick) begin
                        extra_clk <= hit;
                        if (step == LAST_STEP) begin
                            state <= ST_IDLE;
                            step  <= '0;
                            busy  <= 1'b0;
                        end else begin
                            state <= ST_RUN;
                            step  <= step + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    step  <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef TIA_HMOVE_LATE_HBLANK_EN
    localparam logic [3:0] EXT_CLKS = 4'd8;

    logic       hblank_d;
    logic       line_hmove;
    logic       line_hmove_nxt;
    logic [3:0] ext_cnt;

    // A new line (hblank rising) forgets any earlier HMOVE
    assign line_hmove_nxt = (hblank && hmove) ||
                            (line_hmove && !(hblank && !hblank_d));

    // Extension counter is held at 8 while hblank is high on an HMOVE line
    // and counts down once hblank falls.
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            hblank_d   <= 1'b0;
            line_hmove <= 1'b0;
            ext_cnt    <= '0;
        end else begin
            hblank_d   <= hblank;
            line_hmove <= line_hmove_nxt;
            if (hblank)
                ext_cnt <= line_hmove_nxt ? EXT_CLKS : 4'd0;
            else if (ext_cnt != 4'd0)
                ext_cnt <= ext_cnt - 4'd1;
        end
    end

    assign late_hblank = hblank || (ext_cnt != 4'd0);
`endif

endmodule
